// File: rtl/iomem_pkg.sv
// Shared definitions for the two-master iomem arbiter: bus field widths,
// arbiter state encoding and the default read data returned on a slave timeout.
package iomem_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int WSTRB_W = 4;

    localparam logic [DATA_W-1:0] IOMEM_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/iomem_arbiter_if.sv
// PicoRV32 native iomem valid/ready bus. The master modport issues requests,
// the slave modport answers them.
interface iomem_arbiter_if;
    import iomem_pkg::*;

    logic               valid;
    logic               ready;
    logic [WSTRB_W-1:0] wstrb;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [DATA_W-1:0]  rdata;

    modport master (
        output valid, wstrb, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, wstrb, addr, wdata,
        output ready, rdata
    );

endinterface

// File: rtl/iomem_rr_pick.sv
// Two-request round-robin picker: a lone request wins outright, a tie goes
// to the master that was not served last.
module iomem_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any    = |req;
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing the PicoSoC iomem bus between the CPU (m0) and a
// second master (m1). Define IOMEM_ARB_TIMEOUT_EN to enable the stuck-slave timeout.
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_RDATA  = IOMEM_TIMEOUT_RDATA
) (
    input  logic                  clk,
    input  logic                  resetn,
    iomem_arbiter_if.slave        m0,
    iomem_arbiter_if.slave        m1,
    iomem_arbiter_if.master       s,
    output logic                  timeout_flag
);

    arb_state_t state, state_next;
    logic       grant, grant_next;
    logic       last, last_next;
    logic       pick_winner, pick_any;
    logic       g_valid;

`ifdef IOMEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tcnt, tcnt_next;
    logic       flag_next;
`else
    logic unused_params;
    assign unused_params = ^{TIMEOUT_CYCLES, TIMEOUT_RDATA};
    assign timeout_flag  = 1'b0;
`endif

    iomem_rr_pick u_pick (
        .req    ({m1.valid, m0.valid}),
        .last   (last),
        .winner (pick_winner),
        .any    (pick_any)
    );

    assign g_valid = grant ? m1.valid : m0.valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
`ifdef IOMEM_ARB_TIMEOUT_EN
            tcnt         <= 8'd0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            state <= state_next;
            grant <= grant_next;
            last  <= last_next;
`ifdef IOMEM_ARB_TIMEOUT_EN
            tcnt         <= tcnt_next;
            timeout_flag <= flag_next;
`endif
        end
    end

    // Both rdata ports mirror the slave; only the master seeing ready may use it.
    always_comb begin
        state_next = state;
        grant_next = grant;
        last_next  = last;
        s.valid    = 1'b0;
        s.wstrb    = '0;
        s.addr     = '0;
        s.wdata    = '0;
        m0.ready   = 1'b0;
        m1.ready   = 1'b0;
        m0.rdata   = s.rdata;
        m1.rdata   = s.rdata;
`ifdef IOMEM_ARB_TIMEOUT_EN
        tcnt_next  = tcnt;
        flag_next  = timeout_flag;
`endif
        case (state)
            IDLE: begin
`ifdef IOMEM_ARB_TIMEOUT_EN
                tcnt_next = 8'd0;
`endif
                if (pick_any) begin
                    grant_next = pick_winner;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                s.valid = g_valid;
                s.wstrb = grant ? m1.wstrb : m0.wstrb;
                s.addr  = grant ? m1.addr  : m0.addr;
                s.wdata = grant ? m1.wdata : m0.wdata;
                if (s.ready) begin
                    m0.ready   = ~grant;
                    m1.ready   = grant;
                    state_next = IDLE;
                    last_next  = grant;
                end else if (!g_valid) begin
                    state_next = IDLE;
`ifdef IOMEM_ARB_TIMEOUT_EN
                end else if (tcnt == TCNT_LAST) begin
                    s.valid    = 1'b0;
                    m0.ready   = ~grant;
                    m1.ready   = grant;
                    if (grant) begin
                        m1.rdata = TIMEOUT_RDATA;
                    end else begin
                        m0.rdata = TIMEOUT_RDATA;
                    end
                    flag_next  = 1'b1;
                    state_next = IDLE;
                    last_next  = grant;
                end else begin
                    tcnt_next = tcnt + 8'd1;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed scoreboard bench for iomem_arbiter; expected transactions are queued
// in service order and retired when the DUT raises the matching ready.
module tb_iomem_arbiter;
    import iomem_pkg::*;

    typedef struct packed {
        logic        who;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic resetn;
    logic timeout_flag;
    txn_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    iomem_arbiter_if m0_bus();
    iomem_arbiter_if m1_bus();
    iomem_arbiter_if s_bus();

    iomem_arbiter #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_RDATA  (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .m0           (m0_bus),
        .m1           (m1_bus),
        .s            (s_bus),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic who, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb, input logic [31:0] rdata);
        txn_t t;
        t.who   = who;
        t.addr  = addr;
        t.wdata = wdata;
        t.wstrb = wstrb;
        t.rdata = rdata;
        if (who) begin
            m1_bus.valid = 1'b1;
            m1_bus.addr  = addr;
            m1_bus.wdata = wdata;
            m1_bus.wstrb = wstrb;
        end else begin
            m0_bus.valid = 1'b1;
            m0_bus.addr  = addr;
            m0_bus.wdata = wdata;
            m0_bus.wstrb = wstrb;
        end
        exp_q.push_back(t);
    endtask

    task automatic drop_master(input logic who);
        if (who) m1_bus.valid = 1'b0;
        else     m0_bus.valid = 1'b0;
    endtask

    // Waits for s_valid, stalls wait_cycles, completes, then checks the bubble.
    task automatic slave_respond(input string tag, input int exp_lat, input int wait_cycles);
        txn_t t;
        int   n;
        int   bad;
        t = exp_q[0];
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (s_bus.valid !== 1'b1 && n < 20);
        check_output({tag, "_lat"},   32'(n), 32'(exp_lat));
        check_output({tag, "_addr"},  s_bus.addr,  t.addr);
        check_output({tag, "_wdata"}, s_bus.wdata, t.wdata);
        check_output({tag, "_wstrb"}, 32'(s_bus.wstrb), 32'(t.wstrb));
        bad = 0;
        for (int i = 0; i < wait_cycles; i++) begin
            if (s_bus.valid !== 1'b1 || m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0) bad++;
            @(negedge clk);
            #1;
        end
        check_output({tag, "_stall"}, 32'(bad), 32'd0);
        s_bus.ready = 1'b1;
        s_bus.rdata = t.rdata;
        #1;
        check_output({tag, "_m0_ready"}, 32'(m0_bus.ready), 32'(!t.who));
        check_output({tag, "_m1_ready"}, 32'(m1_bus.ready), 32'(t.who));
        check_output({tag, "_rdata"}, t.who ? m1_bus.rdata : m0_bus.rdata, t.rdata);
        void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        check_output({tag, "_bubble"}, 32'({s_bus.valid, m0_bus.ready, m1_bus.ready}), 32'd0);
        s_bus.ready = 1'b0;
        drop_master(t.who);
    endtask

    initial begin
        int bad;
        resetn       = 1'b0;
        m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        s_bus.ready  = 1'b0; s_bus.rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_s_valid",  32'(s_bus.valid), 32'd0);
        check_output("rst_readies",  32'({m0_bus.ready, m1_bus.ready}), 32'd0);
        check_output("rst_s_addr",   s_bus.addr, 32'd0);
        check_output("rst_s_wdata",  s_bus.wdata, 32'd0);
        check_output("rst_s_wstrb",  32'(s_bus.wstrb), 32'd0);
        check_output("rst_flag",     32'(timeout_flag), 32'd0);

        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        $display("[TB] single m0 write");
        apply_stimulus(1'b0, 32'h0300_0000, 32'h0000_00A5, 4'hF, 32'h0000_0000);
        slave_respond("m0_wr", 1, 1);

        $display("[TB] tie after reset, then fairness on m0 re-request");
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus(1'b0, 32'h0300_0010, 32'h1111_0000, 4'h3, 32'hAAAA_0001);
        apply_stimulus(1'b1, 32'h0300_0020, 32'h2222_0000, 4'hC, 32'hBBBB_0002);
        slave_respond("tie_m0", 1, 0);
        apply_stimulus(1'b0, 32'h0300_0030, 32'h3333_0000, 4'h1, 32'hCCCC_0003);
        slave_respond("tie_m1", 2, 0);
        slave_respond("tie_m0b", 2, 0);

        $display("[TB] m1 read");
        apply_stimulus(1'b1, 32'h0300_0004, 32'h0000_0000, 4'h0, 32'h1234_5678);
        slave_respond("m1_rd", 2, 2);

        $display("[TB] m0 withdraws while busy");
        m0_bus.valid = 1'b1;
        m0_bus.addr  = 32'h0300_0040;
        repeat (2) @(negedge clk);
        #1;
        check_output("wd_busy", 32'(s_bus.valid), 32'd1);
        m0_bus.valid = 1'b0;
        #1;
        check_output("wd_s_valid", 32'(s_bus.valid), 32'd0);
        @(posedge clk);
        #1;
        s_bus.ready = 1'b1;
        #1;
        check_output("wd_no_ready", 32'({m0_bus.ready, m1_bus.ready}), 32'd0);
        s_bus.ready = 1'b0;

        $display("[TB] reset while busy");
        m1_bus.valid = 1'b1;
        m1_bus.addr  = 32'h0300_0050;
        repeat (2) @(negedge clk);
        #1;
        check_output("rb_busy", 32'(s_bus.valid), 32'd1);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        s_bus.ready = 1'b1;
        #1;
        check_output("rb_s_valid", 32'(s_bus.valid), 32'd0);
        check_output("rb_s_addr", s_bus.addr, 32'd0);
        check_output("rb_no_ready", 32'({m0_bus.ready, m1_bus.ready}), 32'd0);
        s_bus.ready  = 1'b0;
        m1_bus.valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus(1'b0, 32'h0300_0060, 32'h6666_0000, 4'hF, 32'hDDDD_0004);
        apply_stimulus(1'b1, 32'h0300_0070, 32'h7777_0000, 4'hF, 32'hEEEE_0005);
        slave_respond("rb_m0", 1, 0);
        slave_respond("rb_m1", 2, 0);

`ifdef IOMEM_ARB_TIMEOUT_EN
        $display("[TB] stuck slave timeout");
        m0_bus.valid = 1'b1;
        m0_bus.addr  = 32'h0300_0080;
        repeat (2) @(negedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            if (s_bus.valid !== 1'b1 || m0_bus.ready !== 1'b0) bad++;
            @(negedge clk);
            #1;
        end
        check_output("to_wait", 32'(bad), 32'd0);
        check_output("to_m0_ready", 32'(m0_bus.ready), 32'd1);
        check_output("to_m1_ready", 32'(m1_bus.ready), 32'd0);
        check_output("to_rdata", m0_bus.rdata, 32'hDEAD_BEEF);
        check_output("to_s_valid", 32'(s_bus.valid), 32'd0);
        @(posedge clk);
        #1;
        m0_bus.valid = 1'b0;
        check_output("to_flag_set", 32'(timeout_flag), 32'd1);
        apply_stimulus(1'b1, 32'h0300_0090, 32'h9999_0000, 4'hF, 32'h0000_0009);
        slave_respond("to_after", 2, 1);
        check_output("to_flag_sticky", 32'(timeout_flag), 32'd1);
`else
        $display("[TB] slow slave without timeout");
        bad = 0;
        apply_stimulus(1'b0, 32'h0300_0008, 32'h0000_005A, 4'h1, 32'h0BAD_F00D);
        slave_respond("long_wait", 2, 300);
        check_output("long_flag", 32'(timeout_flag + 1'(bad)), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Two-master arbiter sharing the PicoSoC iomem peripheral bus between the CPU (`picosoc` iomem port) and a second bus master (debug loader / DMA). Sits between both masters and the existing iomem slave decode (GPIO register at 0x03xx_xxxx and later peripherals). Round-robin grant, one transaction per grant, native PicoRV32 valid/ready handshake on all ports, optional stuck-slave timeout.

## Interface
- `TIMEOUT_CYCLES`, 255: slave cycles allowed before forced completion (timeout build only); range 1..255.
- `TIMEOUT_RDATA`, 32'hDEAD_BEEF: read data returned on timeout.
- `clk` in 1: system clock; single clock domain.
- `resetn` in 1: synchronous, active-low reset.
- `m0_valid` in 1, `m0_wstrb` in 4, `m0_addr` in 32, `m0_wdata` in 32: CPU request.
- `m0_ready` out 1, `m0_rdata` out 32: CPU completion.
- `m1_valid` in 1, `m1_wstrb` in 4, `m1_addr` in 32, `m1_wdata` in 32: second-master request.
- `m1_ready` out 1, `m1_rdata` out 32: second-master completion.
- `s_valid` out 1, `s_wstrb` out 4, `s_addr` out 32, `s_wdata` out 32: shared slave request.
- `s_ready` in 1, `s_rdata` in 32: shared slave completion.
- `timeout_flag` out 1: sticky, set on any forced completion; cleared only by reset.

## Operation
- FSM states: IDLE, BUSY. Registers: `state`, `grant` (0/1), `last` (last master served), `tcnt` (8 bit).
- IDLE: if exactly one `mX_valid`, `grant<=X`; if both, `grant<=~last`; then `state<=BUSY`. No request: stay.
- BUSY: `s_valid = mG_valid`; `s_wstrb/s_addr/s_wdata` = granted master's fields (muxed by `grant`, zero when IDLE).
- `mG_ready = s_ready` in BUSY; `mG_rdata = s_rdata` (both masters' rdata may show `s_rdata`; only the ready'd one is meaningful). Non-granted ready always 0.
- BUSY with `s_ready`=1: `state<=IDLE`, `last<=grant`.
- BUSY with `mG_valid`=0 (master withdrew, protocol error): `state<=IDLE`, `last` unchanged, no ready generated.
- Simultaneous `s_ready` and withdrawal: treated as completion.
- Non-granted master's request is held pending, never dropped; it wins the next arbitration if the other master re-requests immediately (fairness: max one waiting transaction).
- Reset: `state=IDLE`, `grant=0`, `last=1` (m0 wins first tie), `tcnt=0`, `timeout_flag=0`.

## Timing
- Request at cycle N in IDLE -> `s_valid` at N+1 (one-cycle arbitration latency).
- `s_ready` at cycle K -> `mG_ready` at K, combinational pass-through, single-cycle pulse.
- Cycle K+1 is always IDLE (one bubble between transactions); slaves using `valid && !ready` gating see `s_valid`=0 at K+1.
- Reset values of outputs from first clock edge with `resetn`=0: all `*_ready`=0, `s_valid`=0, `s_addr/s_wdata/s_wstrb`=0, `timeout_flag`=0. Reset mid-BUSY aborts without a ready pulse.

## Configuration
- `IOMEM_ARB_TIMEOUT_EN` defined: `tcnt` clears on entering BUSY, increments each BUSY cycle without `s_ready`; when `tcnt == TIMEOUT_CYCLES-1` and `s_ready`=0, arbiter drives `mG_ready`=1, `mG_rdata=TIMEOUT_RDATA`, `s_valid`=0 that cycle, sets `timeout_flag`, returns IDLE. `s_ready` in that same cycle takes precedence (normal completion).
- Undefined: no counter; BUSY waits indefinitely; `timeout_flag` tied 0; `TIMEOUT_*` parameters unused.

## Structure
- Shared package `iomem_pkg`: state encoding (IDLE/BUSY), `IOMEM_TIMEOUT_RDATA` default constant, bus field widths (ADDR 32, DATA 32, WSTRB 4).
- One sub-module `iomem_rr_pick`: 2-request round-robin picker (inputs req[1:0], last; output winner, any). Remaining logic in `iomem_arbiter`.

## Test plan
- m0 write addr 0x0300_0000 wdata 0x0000_00A5 wstrb 0xF, slave ready 1 cycle after `s_valid` -> `s_valid` at N+1, `m0_ready` at N+2, `m1_ready` stays 0.
- m0 and m1 both request at same cycle after reset -> m0 served first, m1 granted in the IDLE cycle after m0's ready; second tie -> m1 first (alternation).
- m1 read, slave returns `s_rdata`=0x1234_5678 -> `m1_rdata`=0x1234_5678 with `m1_ready` pulse exactly 1 cycle.
- `resetn` low while BUSY with slave not ready -> next edge `s_valid`=0, no ready pulse, subsequent request arbitrates from m0.
- With `IOMEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, slave never ready -> `m0_ready` on 4th BUSY cycle, `m0_rdata`=0xDEAD_BEEF, `timeout_flag`=1 and stays 1.
- Without macro, slave ready after 300 cycles -> normal completion, `timeout_flag`=0.
